// File: rtl/fb_pkg.sv
// Shared framebuffer constants, grant encoding and in-flight read tags.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package fb_pkg;

  localparam int FB_ADDR_W      = 19;
  localparam int FB_DATA_W      = 24;      // {R[7:0],G[7:0],B[7:0]}
  localparam int FB_FRAME_WORDS = 307200;  // 640x480

  // Owner of the RAM port in the current cycle.
  localparam logic [1:0] GNT_NONE = 2'd0;
  localparam logic [1:0] GNT_CPU  = 2'd1;
  localparam logic [1:0] GNT_VGA  = 2'd2;

  // Who owns the read data returning from RAM this cycle.
  typedef enum logic [1:0] {
    TAG_NONE = 2'd0,
    TAG_CPU  = 2'd1,
    TAG_VGA  = 2'd2
  } tag_e;

endpackage

// File: rtl/fb_pix_fifo.sv
// Synchronous show-ahead FIFO with flush and occupancy count.
// Latency: a push is visible at data_o the cycle after it is written.
// Backpressure: none; caller must not push when full or pop when empty.
// Ports: clk_i/rst_i (sync, active-high), flush_i empties the FIFO and wins
//   over push_i/pop_i; push_i/data_i write; pop_i advances the head;
//   data_o is the head (0 when empty); empty_o; count_o = entries held.
module fb_pix_fifo #(
  parameter int DW    = 24,
  parameter int DEPTH = 16
) (
  input  logic                       clk_i,
  input  logic                       rst_i,
  input  logic                       flush_i,
  input  logic                       push_i,
  input  logic [DW-1:0]              data_i,
  input  logic                       pop_i,
  output logic [DW-1:0]              data_o,
  output logic                       empty_o,
  output logic [$clog2(DEPTH):0]     count_o
);

  localparam int AW = $clog2(DEPTH);

  logic [DW-1:0] mem_q [DEPTH];
  logic [AW-1:0] wr_ptr_q, rd_ptr_q;
  logic [AW:0]   cnt_q;

  // Storage carries no reset; only the pointers define validity.
  always_ff @(posedge clk_i) begin
    if (push_i && !flush_i) begin
      mem_q[wr_ptr_q] <= data_i;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i || flush_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
    end else begin
      if (push_i) wr_ptr_q <= wr_ptr_q + AW'(1);
      if (pop_i)  rd_ptr_q <= rd_ptr_q + AW'(1);
      case ({push_i, pop_i})
        2'b10:   cnt_q <= cnt_q + (AW+1)'(1);
        2'b01:   cnt_q <= cnt_q - (AW+1)'(1);
        default: cnt_q <= cnt_q;
      endcase
    end
  end

  assign empty_o = (cnt_q == '0);
  assign data_o  = empty_o ? '0 : mem_q[rd_ptr_q];
  assign count_o = cnt_q;

endmodule

// File: rtl/vga_fb_arbiter.sv
// Shares one single-port sync framebuffer RAM between CPU load/store and VGA scanout prefetch.
// Latency: CPU write lands in the accept cycle; CPU read data 1 cycle after accept; VGA word pushed 1 cycle after issue.
// Backpressure: cpu_ready drops only while the pixel FIFO is at/below the low watermark and a fetch is possible.
// Ports: clk/rst (sync, active-high); cpu_valid/we/addr/wdata/ready request, cpu_rvalid/rdata response;
//   vga_frame_start restarts scan, vga_pop/vga_pix/vga_empty show-ahead pixel stream, vga_underrun sticky;
//   mem_en/we/addr/wdata drive the RAM, mem_rdata returns one cycle after a read.
module vga_fb_arbiter
  import fb_pkg::*;
#(
  parameter int ADDR_W      = FB_ADDR_W,
  parameter int DATA_W      = FB_DATA_W,
  parameter int FRAME_WORDS = FB_FRAME_WORDS,
  parameter int FIFO_DEPTH  = 16,
  parameter int LOW_WM      = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              cpu_valid,
  input  logic              cpu_we,
  input  logic [ADDR_W-1:0] cpu_addr,
  input  logic [DATA_W-1:0] cpu_wdata,
  output logic              cpu_ready,
  output logic              cpu_rvalid,
  output logic [DATA_W-1:0] cpu_rdata,
  input  logic              vga_frame_start,
  input  logic              vga_pop,
  output logic [DATA_W-1:0] vga_pix,
  output logic              vga_empty,
  output logic              vga_underrun,
  output logic              mem_en,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata
);

  localparam int                CNT_W     = $clog2(FIFO_DEPTH) + 1;
  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(FRAME_WORDS - 1);

  logic [ADDR_W-1:0] fetch_ptr_q, fetch_ptr_d;
  logic              fetch_done_q, fetch_done_d;
  tag_e              tag_q, tag_d;
  logic              underrun_q, underrun_d;
  logic [DATA_W-1:0] rdata_q, rdata_d;

  logic [CNT_W-1:0]  fifo_count;
  logic              fifo_empty;
  logic              fifo_push, fifo_pop;
  logic              vga_inflight, credit_ok, want_vga, urgent;
  logic [CNT_W:0]    level;
  logic [1:0]        gnt;

  // Credit counts the in-flight read so a push can never land on a full FIFO.
  assign vga_inflight = (tag_q == TAG_VGA);
  assign level        = {1'b0, fifo_count} + {{CNT_W{1'b0}}, vga_inflight};
  assign credit_ok    = level < (CNT_W+1)'(FIFO_DEPTH);
  assign want_vga     = !fetch_done_q && credit_ok && !vga_frame_start;
  assign urgent       = want_vga && (fifo_count <= CNT_W'(LOW_WM));
  assign cpu_ready    = !rst && !urgent;

  always_comb begin
    gnt = GNT_NONE;
    if (!rst) begin
      if (urgent)         gnt = GNT_VGA;
      else if (cpu_valid) gnt = GNT_CPU;
      else if (want_vga)  gnt = GNT_VGA;
    end
  end

  assign mem_en    = (gnt != GNT_NONE);
  assign mem_we    = (gnt == GNT_CPU) && cpu_we;
  assign mem_addr  = (gnt == GNT_VGA) ? fetch_ptr_q :
                     (gnt == GNT_CPU) ? cpu_addr : '0;
  assign mem_wdata = mem_we ? cpu_wdata : '0;

  // A frame_start in the return cycle also flushes, so the stale word is lost.
  assign fifo_push = vga_inflight && !vga_frame_start;
  assign fifo_pop  = vga_pop && !fifo_empty && !vga_frame_start;

  always_comb begin
    fetch_ptr_d  = fetch_ptr_q;
    fetch_done_d = fetch_done_q;
    if (vga_frame_start) begin
      fetch_ptr_d  = '0;
      fetch_done_d = 1'b0;
    end else if (gnt == GNT_VGA) begin
      fetch_ptr_d = fetch_ptr_q + ADDR_W'(1);
      if (fetch_ptr_q == LAST_ADDR) fetch_done_d = 1'b1;
    end

    tag_d = TAG_NONE;
    if (gnt == GNT_VGA)                 tag_d = TAG_VGA;
    else if (gnt == GNT_CPU && !cpu_we) tag_d = TAG_CPU;

    underrun_d = underrun_q || (vga_pop && fifo_empty && !vga_frame_start);
    rdata_d    = (tag_q == TAG_CPU) ? mem_rdata : rdata_q;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      fetch_ptr_q  <= '0;
      fetch_done_q <= 1'b1;
      tag_q        <= TAG_NONE;
      underrun_q   <= 1'b0;
      rdata_q      <= '0;
    end else begin
      fetch_ptr_q  <= fetch_ptr_d;
      fetch_done_q <= fetch_done_d;
      tag_q        <= tag_d;
      underrun_q   <= underrun_d;
      rdata_q      <= rdata_d;
    end
  end

  assign cpu_rvalid   = !rst && (tag_q == TAG_CPU);
  assign cpu_rdata    = rst ? '0 : rdata_d;
  assign vga_underrun = underrun_q;
  assign vga_empty    = fifo_empty;

  fb_pix_fifo #(
    .DW    (DATA_W),
    .DEPTH (FIFO_DEPTH)
  ) u_pix_fifo (
    .clk_i   (clk),
    .rst_i   (rst),
    .flush_i (vga_frame_start),
    .push_i  (fifo_push),
    .data_i  (mem_rdata),
    .pop_i   (fifo_pop),
    .data_o  (vga_pix),
    .empty_o (fifo_empty),
    .count_o (fifo_count)
  );

endmodule
